// File: rtl/sdram_sched.sv
// Command scheduler for the shared SDRAM: arbitrates three request channels plus refresh.
// Optional ch2 anti-starvation promotion is enabled by defining SDRAM_SCHED_STARVE_EN.
module sdram_sched #(
  parameter int REFRESH_INTERVAL = 1500,
  parameter int MAX_DEBT         = 8,
  parameter int STARVE_LIMIT     = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  output logic [2:0] gnt,
  input  logic       refresh_hint,
  output logic       cmd_valid,
  output logic [1:0] cmd_ch,
  input  logic       cmd_ready,
  input  logic       cmd_done,
  output logic [3:0] refresh_debt,
  output logic       refresh_err,
  output logic       busy
);

  localparam int TW = (REFRESH_INTERVAL > 2) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(REFRESH_INTERVAL - 1);
  localparam logic [3:0]    DEBT_MAX   = 4'(MAX_DEBT);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] BUSY  = 2'd2;

  localparam logic [1:0] CH_RFSH = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    debt_q, debt_d;
  logic          err_q, err_d;
  logic          hint_q, hint_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic [1:0]    cmd_ch_q, cmd_ch_d;
  logic [2:0]    gnt_q, gnt_d;

  logic tick;
  logic handshake;
  logic rfsh_hs;
  logic urgent;
  logic hinted;
  logic ch2_hi;

`ifdef SDRAM_SCHED_STARVE_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  logic [SW-1:0] starve_q, starve_d;

  always_comb begin
    starve_d = starve_q;
    if (gnt_q[2]) begin
      starve_d = '0;
    end else if (req[2] && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  assign ch2_hi = (starve_q == STARVE_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign ch2_hi = 1'b0;
`endif

  assign tick      = (timer_q == TIMER_LAST);
  assign handshake = (state_q == ISSUE) && cmd_valid_q && cmd_ready;
  assign rfsh_hs   = handshake && (cmd_ch_q == CH_RFSH);
  assign urgent    = (debt_q == DEBT_MAX);
  assign hinted    = hint_q && (debt_q != 4'd0);

  always_comb begin
    timer_d     = tick ? '0 : timer_q + TW'(1);
    debt_d      = debt_q;
    err_d       = err_q | (tick && urgent);
    hint_d      = hint_q;
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    cmd_ch_d    = cmd_ch_q;
    gnt_d       = 3'b000;

    // A tick and a refresh handshake in the same cycle cancel out.
    if (tick && !rfsh_hs) begin
      if (!urgent) debt_d = debt_q + 4'd1;
    end else if (rfsh_hs && !tick) begin
      if (debt_q != 4'd0) debt_d = debt_q - 4'd1;
    end

    if (rfsh_hs) begin
      hint_d = 1'b0;
    end else if (refresh_hint && (debt_q != 4'd0)) begin
      hint_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (urgent || req[0] || req[1] || req[2] || hinted) begin
          cmd_valid_d = 1'b1;
          state_d     = ISSUE;
          if (urgent)              cmd_ch_d = CH_RFSH;
          else if (req[0])         cmd_ch_d = 2'd0;
          else if (ch2_hi && req[2]) cmd_ch_d = 2'd2;
          else if (req[1])         cmd_ch_d = 2'd1;
          else if (hinted)         cmd_ch_d = CH_RFSH;
          else                     cmd_ch_d = 2'd2;
        end
      end
      ISSUE: begin
        if (handshake) begin
          cmd_valid_d = 1'b0;
          state_d     = BUSY;
          if (cmd_ch_q != CH_RFSH) gnt_d = 3'b001 << cmd_ch_q;
        end
      end
      BUSY: begin
        if (cmd_done) state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        cmd_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      debt_q      <= 4'd0;
      err_q       <= 1'b0;
      hint_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_ch_q    <= 2'd0;
      gnt_q       <= 3'b000;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      debt_q      <= debt_d;
      err_q       <= err_d;
      hint_q      <= hint_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_ch_q    <= cmd_ch_d;
      gnt_q       <= gnt_d;
    end
  end

  assign gnt          = gnt_q;
  assign cmd_valid    = cmd_valid_q;
  assign cmd_ch       = cmd_ch_q;
  assign refresh_debt = debt_q;
  assign refresh_err  = err_q;
  assign busy         = (state_q == ISSUE) || (state_q == BUSY);

endmodule
